// File: rtl/hack_data_memory.sv
// Hack CPU data-bus responder: RAM, screen shadow with buffered video write queue, keyboard register.
// Reads are registered (one-cycle latency); CPU writes commit on a single sub-cycle of each CPU cycle.
module hack_data_memory #(
    parameter int CLK_COUNT_WRITE = 10,
    parameter int SCR_FIFO_DEPTH  = 4
) (
    input  logic        CLK_100MHz,
    input  logic        RESET,
    input  logic        CLK_CPU,
    input  logic [31:0] CLK_COUNT,
    input  logic [15:0] ADDRESS_M,
    input  logic [15:0] OUT_M,
    input  logic        LOAD_M,
    output logic [15:0] IN_M,
    output logic        SCR_WR_VALID,
    output logic [12:0] SCR_WR_ADDR,
    output logic [15:0] SCR_WR_DATA,
    input  logic        SCR_WR_READY,
    input  logic        KBD_VALID,
    input  logic [15:0] KBD_CODE,
    output logic        SCR_OVERFLOW
);
    localparam int PTR_W = $clog2(SCR_FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(SCR_FIFO_DEPTH);

    logic [15:0] ram    [0:16383];
    logic [15:0] shadow [0:8191];
    logic [12:0] q_addr [0:SCR_FIFO_DEPTH-1];
    logic [15:0] q_data [0:SCR_FIFO_DEPTH-1];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   q_count;
    logic [15:0]      kbd;
    logic [15:0]      rd_data_p1;
    logic             overflow;

    logic        is_ram;
    logic        is_scr;
    logic        is_kbd;
    logic        wr_fire;
    logic        scr_push;
    logic        scr_pop;
    logic        q_full;
    logic        push_ok;
    logic [15:0] rd_mux;

    assign is_ram = (ADDRESS_M[15:14] == 2'b00);
    assign is_scr = (ADDRESS_M[15:13] == 3'b010);
    assign is_kbd = (ADDRESS_M == 16'h6000);

    // A write in the reset cycle must not touch storage either.
    assign wr_fire  = LOAD_M & CLK_CPU & (CLK_COUNT == 32'(CLK_COUNT_WRITE)) & ~RESET;
    assign scr_push = wr_fire & is_scr;
    assign scr_pop  = SCR_WR_VALID & SCR_WR_READY;
    assign q_full   = (q_count == FULL_CNT);
    assign push_ok  = scr_push & (~q_full | scr_pop);

    always_comb begin
        rd_mux = 16'h0000;
        if (is_ram)
            rd_mux = ram[ADDRESS_M[13:0]];
        else if (is_scr)
            rd_mux = shadow[ADDRESS_M[12:0]];
        else if (is_kbd)
            rd_mux = kbd;
    end

    // Storage: never cleared by reset.
    always_ff @(posedge CLK_100MHz) begin
        if (wr_fire && is_ram)
            ram[ADDRESS_M[13:0]] <= OUT_M;
        if (scr_push)
            shadow[ADDRESS_M[12:0]] <= OUT_M;
        if (push_ok) begin
            q_addr[wr_ptr] <= ADDRESS_M[12:0];
            q_data[wr_ptr] <= OUT_M;
        end
    end

    // Read stage p1, queue control, keyboard register, sticky overflow.
    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            rd_data_p1 <= 16'h0000;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            kbd        <= 16'h0000;
            overflow   <= 1'b0;
        end else begin
            rd_data_p1 <= rd_mux;
            if (KBD_VALID)
                kbd <= KBD_CODE;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (scr_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, scr_pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            if (scr_push && !push_ok)
                overflow <= 1'b1;
        end
    end

    assign IN_M         = rd_data_p1;
    assign SCR_WR_VALID = (q_count != '0);
    assign SCR_WR_ADDR  = SCR_WR_VALID ? q_addr[rd_ptr] : 13'h0000;
    assign SCR_WR_DATA  = SCR_WR_VALID ? q_data[rd_ptr] : 16'h0000;
    assign SCR_OVERFLOW = overflow;

endmodule
